// File: rtl/divider_pkg.sv
// Shared types and constants for the divider result BCD stage.
package divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t CONVERT = 2'd1;
  localparam state_t HOLD    = 2'd2;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 (mod 16)
// so the following left shift carries correctly into the next digit.
module bcd_add3
  import divider_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/divider_result_bcd.sv
// Captures divider quotient/remainder and converts both to packed BCD by
// sequential double-dabble. Define BCD_BLANK_EN to add leading-zero blank masks.
module divider_result_bcd
  import divider_pkg::*;
#(
  parameter int SIZE   = 2,
  parameter int DIGITS = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            done,
  input  logic                            error,
  input  logic [SIZE-1:0]                 quotient,
  input  logic [SIZE-1:0]                 remainder,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   q_bcd,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   r_bcd,
  output logic                            bcd_valid,
  output logic                            div_err,
  output logic                            busy
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]               q_blank,
  output logic [DIGITS-1:0]               r_blank
`endif
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(SIZE + 1);

  state_t          state;
  logic [SIZE-1:0] q_sh;
  logic [SIZE-1:0] r_sh;
  logic [BW-1:0]   q_acc;
  logic [BW-1:0]   r_acc;
  logic [BW-1:0]   q_adj;
  logic [BW-1:0]   r_adj;
  logic [BW-1:0]   q_acc_next;
  logic [BW-1:0]   r_acc_next;
  logic [CW-1:0]   cnt;
  logic            evt_d;
  logic            accept;
  logic            finish;
  logic            unused_top;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_add3 u_q_add3 (
        .digit   (q_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .adjusted(q_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
      bcd_add3 u_r_add3 (
        .digit   (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .adjusted(r_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // The adjusted MSB is always shifted out; the DIGITS sizing rule keeps it zero.
  assign unused_top = q_adj[BW-1] ^ r_adj[BW-1];
  assign q_acc_next = {q_adj[BW-2:0], q_sh[SIZE-1]};
  assign r_acc_next = {r_adj[BW-2:0], r_sh[SIZE-1]};

  // Only a rising edge of done|error is an event; levels held high do not re-trigger.
  assign accept = (done | error) & ~evt_d & (state != CONVERT);
  assign finish = (state == CONVERT) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      q_sh      <= '0;
      r_sh      <= '0;
      q_acc     <= '0;
      r_acc     <= '0;
      cnt       <= '0;
      evt_d     <= 1'b0;
      q_bcd     <= '0;
      r_bcd     <= '0;
      bcd_valid <= 1'b0;
      div_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      evt_d <= done | error;
      if (state == CONVERT) begin
        q_acc <= q_acc_next;
        r_acc <= r_acc_next;
        q_sh  <= {q_sh[SIZE-2:0], 1'b0};
        r_sh  <= {r_sh[SIZE-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
        if (finish) begin
          q_bcd     <= q_acc_next;
          r_bcd     <= r_acc_next;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= HOLD;
        end
      end else if (accept) begin
        if (error) begin
          q_bcd     <= '0;
          r_bcd     <= '0;
          bcd_valid <= 1'b1;
          div_err   <= 1'b1;
          busy      <= 1'b0;
          state     <= HOLD;
        end else begin
          q_sh      <= quotient;
          r_sh      <= remainder;
          q_acc     <= '0;
          r_acc     <= '0;
          cnt       <= CW'(SIZE);
          bcd_valid <= 1'b0;
          div_err   <= 1'b0;
          busy      <= 1'b1;
          state     <= CONVERT;
        end
      end
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] q_blank_next;
  logic [DIGITS-1:0] r_blank_next;
  logic [DIGITS-1:0] err_blank;
  logic              q_run;
  logic              r_run;

  // Walk down from the top digit; a digit blanks while everything above it is zero.
  always_comb begin
    q_blank_next = '0;
    r_blank_next = '0;
    err_blank    = '1;
    err_blank[0] = 1'b0;
    q_run        = 1'b1;
    r_run        = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      q_run           = q_run & (q_acc_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      r_run           = r_run & (r_acc_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      q_blank_next[i] = q_run;
      r_blank_next[i] = r_run;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_blank <= '0;
      r_blank <= '0;
    end else if (finish) begin
      q_blank <= q_blank_next;
      r_blank <= r_blank_next;
    end else if (accept && error) begin
      q_blank <= err_blank;
      r_blank <= err_blank;
    end
  end
`endif

endmodule
